wav_byte_fetch: RTL and testbench
=================================

Name: wav_byte_fetch

Overview:
- Byte-read front end between the wave player's byte port and the SDRAM 64-bit sample-read port.
- Holds one 8-byte line, so sequential playback hits SDRAM only once per 8 bytes.
- Upstream side: byte address plus level read request, returns byte plus ready.
- Downstream side: toggle request/ack handshake to the SDRAM controller, 64-bit line data.

Parameters:
ADDR_W, 28, byte address width from wave player; line address is ADDR_W-3 bits
RESET_READY, 1, value of o_ready out of reset / with no request pending

Ports:
clk_sys  in  1  system clock (40 MHz)
reset_n  in  1  asynchronous active-low reset
i_addr  in  ADDR_W  byte address, sampled on i_rd rising edge
i_rd  in  1  read strobe; each rising edge is one byte request
i_flush  in  1  invalidate held line (sample reload / playback stop)
o_data  out  8  returned byte
o_ready  out  1  high = o_data valid for last request
o_sd_addr  out  ADDR_W-3  line address to SDRAM (i_addr[ADDR_W-1:3])
o_sd_req  out  1  request toggle
i_sd_ack  in  1  ack toggle; equals o_sd_req when no request is pending
i_sd_data  in  64  line data, valid on the cycle ack toggles

Behaviour:
- Reset (async, reset_n=0):
  - o_data=0, o_ready=RESET_READY, o_sd_req=0, o_sd_addr=0.
  - Line valid=0, tag=0, state IDLE.
  - SDRAM side resets ack to 0 concurrently.
- Edge detect: registered copy of i_rd; request = i_rd & ~i_rd_q. On a request, i_addr is latched into req_addr.
- Byte select is little-endian: byte k = line[8k+7:8k], k=req_addr[2:0].
- States: IDLE, FETCH, DONE.
- IDLE, request, hit (valid & tag==i_addr[ADDR_W-1:3]):
  - Next cycle: o_data=byte, o_ready=1.
  - Latency 1 clk, no SDRAM traffic.
- IDLE, request, miss:
  - Next cycle: o_ready=0, o_sd_addr=i_addr[ADDR_W-1:3], o_sd_req toggles, state FETCH.
- FETCH:
  - Wait for i_sd_ack==o_sd_req.
  - On that cycle, capture i_sd_data into line, tag=o_sd_addr, valid=1, state DONE.
- DONE (one cycle): o_data=selected byte, o_ready=1, state IDLE.
- Miss latency: 2 clk + SDRAM ack delay.
- Requests arriving in FETCH or DONE are ignored (not queued). The requester must wait for o_ready.
- i_flush in IDLE/DONE: valid=0 next cycle. o_ready and o_data are unchanged.
- i_flush in FETCH:
  - Sets abort flag; the outstanding ack is still consumed (toggle parity must stay aligned).
  - On ack: data is not stored, valid=0, o_ready=1, o_data unchanged, state IDLE.
- Flush coincident with a request in IDLE: flush wins. The request is treated as a miss.
- Tag compare is full width; address wrap at 2^ADDR_W needs no special case.
- Ack toggling while not in FETCH is a protocol error. It is ignored, and parity is resynchronised by the next fill's comparison.

Optional Feature:
- Macro: WAV_FETCH_PREFETCH_EN.
- Defined:
  - Adds a second line register (next line) with its own valid flag and tag.
  - On a hit to byte offset 7, or on completion of a demand fill, a prefetch of tag+1 is issued (state PREFETCH) if the next line is not already held.
  - While PREFETCH is outstanding, o_ready stays 1 and hits in the current line are still served.
  - A request to tag+1 either promotes the next line to the current line (latency 1 clk), or, if its fetch is still in flight, waits in FETCH for that ack.
  - Any other miss waits for the prefetch ack to land before issuing its own fetch.
  - Flush invalidates both lines.
- Undefined: single line, behaviour exactly as above.

Test Plan:
- Reset: reset_n low mid-FETCH, then release -> o_ready=1, o_sd_req=0, o_data=0; next read at 0x10 misses.
- Cold miss + hits:
  - Read 0x000008 with ack 3 clk later and i_sd_data=0x8877665544332211 -> o_sd_addr=1, one req toggle, o_data=0x11.
  - Reads 0x09..0x0F -> 0x22..0x88, each 1 clk, no req toggle.
- Line crossing: sequential reads 0x0F then 0x10 -> second read toggles req with o_sd_addr=2. Prefetch build: no extra toggle, o_ready at 1 clk.
- Flush mid-fetch: i_flush during FETCH, ack arrives -> o_ready=1, valid=0. A repeat read of the same address issues a new toggle.
- Ignored request: second i_rd edge during FETCH -> exactly one req toggle; o_data corresponds to the first address.
- Byte lanes: line 0xF0E0D0C0B0A09080, read offsets 7,0,3 -> 0xF0, 0x80, 0xB0.

Source files
------------

// File: rtl/wav_byte_fetch.sv
// Byte-read front end for the wave player: holds one 8-byte SDRAM line and serves byte reads from it.
// Define WAV_FETCH_PREFETCH_EN to add a next-line register filled by a background prefetch.
module wav_byte_fetch #(
  parameter int ADDR_W      = 28,
  parameter bit RESET_READY = 1'b1
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              i_rd,
  input  logic              i_flush,
  output logic [7:0]        o_data,
  output logic              o_ready,
  output logic [ADDR_W-4:0] o_sd_addr,
  output logic              o_sd_req,
  input  logic              i_sd_ack,
  input  logic [63:0]       i_sd_data
);
  localparam int TAG_W = ADDR_W - 3;

`ifdef WAV_FETCH_PREFETCH_EN
  typedef enum logic [1:0] {IDLE, FETCH, DONE, PREFETCH} state_t;
`else
  typedef enum logic [1:0] {IDLE, FETCH, DONE} state_t;
`endif

  state_t           state_q, state_d;
  logic             rd_q;
  logic [2:0]       req_off_q, req_off_d;
  logic [7:0]       data_q, data_d;
  logic             ready_q, ready_d;
  logic [TAG_W-1:0] sd_addr_q, sd_addr_d;
  logic             sd_req_q, sd_req_d;
  logic [63:0]      line_q, line_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic             valid_q, valid_d;
  logic             abort_q, abort_d;

  logic             rd_edge, ack_now, hit_cur;
  logic [TAG_W-1:0] i_tag;

  assign i_tag   = i_addr[ADDR_W-1:3];
  assign rd_edge = i_rd & ~rd_q;
  assign ack_now = (i_sd_ack == sd_req_q);
  assign hit_cur = valid_q && (tag_q == i_tag);

  function automatic logic [7:0] sel_byte(input logic [63:0] line, input logic [2:0] k);
    return line[{k, 3'b000} +: 8];
  endfunction

`ifdef WAV_FETCH_PREFETCH_EN
  localparam logic [TAG_W-1:0] TAG_ONE = TAG_W'(1);

  logic [63:0]      nline_q, nline_d;
  logic [TAG_W-1:0] ntag_q, ntag_d;
  logic             nvalid_q, nvalid_d;
  logic             miss_pend_q, miss_pend_d;
  logic [TAG_W-1:0] pend_tag_q, pend_tag_d;
  logic             hit_nxt, nxt_held, off7;

  assign hit_nxt  = nvalid_q && (ntag_q == i_tag);
  assign nxt_held = nvalid_q && (ntag_q == tag_q + TAG_ONE);
  assign off7     = &i_addr[2:0];

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      nline_q     <= '0;
      ntag_q      <= '0;
      nvalid_q    <= 1'b0;
      miss_pend_q <= 1'b0;
      pend_tag_q  <= '0;
    end else begin
      nline_q     <= nline_d;
      ntag_q      <= ntag_d;
      nvalid_q    <= nvalid_d;
      miss_pend_q <= miss_pend_d;
      pend_tag_q  <= pend_tag_d;
    end
  end
`endif

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      rd_q      <= 1'b0;
      req_off_q <= 3'd0;
      data_q    <= 8'd0;
      ready_q   <= RESET_READY;
      sd_addr_q <= '0;
      sd_req_q  <= 1'b0;
      line_q    <= '0;
      tag_q     <= '0;
      valid_q   <= 1'b0;
      abort_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      rd_q      <= i_rd;
      req_off_q <= req_off_d;
      data_q    <= data_d;
      ready_q   <= ready_d;
      sd_addr_q <= sd_addr_d;
      sd_req_q  <= sd_req_d;
      line_q    <= line_d;
      tag_q     <= tag_d;
      valid_q   <= valid_d;
      abort_q   <= abort_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    req_off_d = req_off_q;
    data_d    = data_q;
    ready_d   = ready_q;
    sd_addr_d = sd_addr_q;
    sd_req_d  = sd_req_q;
    line_d    = line_q;
    tag_d     = tag_q;
    valid_d   = valid_q;
    abort_d   = abort_q;
`ifdef WAV_FETCH_PREFETCH_EN
    nline_d     = nline_q;
    ntag_d      = ntag_q;
    nvalid_d    = nvalid_q;
    miss_pend_d = miss_pend_q;
    pend_tag_d  = pend_tag_q;
    if (i_flush) nvalid_d = 1'b0;
`endif
    // A flush always drops the held line; later branches only revalidate when no flush is present.
    if (i_flush) valid_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (rd_edge) begin
          req_off_d = i_addr[2:0];
          if (!i_flush && hit_cur) begin
            data_d  = sel_byte(line_q, i_addr[2:0]);
            ready_d = 1'b1;
`ifdef WAV_FETCH_PREFETCH_EN
            if (off7 && !nxt_held) begin
              sd_addr_d = tag_q + TAG_ONE;
              sd_req_d  = ~sd_req_q;
              abort_d   = 1'b0;
              state_d   = PREFETCH;
            end
          end else if (!i_flush && hit_nxt) begin
            line_d   = nline_q;
            tag_d    = ntag_q;
            valid_d  = 1'b1;
            nvalid_d = 1'b0;
            data_d   = sel_byte(nline_q, i_addr[2:0]);
            ready_d  = 1'b1;
            if (off7) begin
              sd_addr_d = ntag_q + TAG_ONE;
              sd_req_d  = ~sd_req_q;
              abort_d   = 1'b0;
              state_d   = PREFETCH;
            end
`endif
          end else begin
            ready_d   = 1'b0;
            sd_addr_d = i_tag;
            sd_req_d  = ~sd_req_q;
            abort_d   = 1'b0;
            state_d   = FETCH;
          end
        end
      end

      FETCH: begin
        if (i_flush) abort_d = 1'b1;
        if (ack_now) begin
          abort_d = 1'b0;
          if (abort_q || i_flush) begin
            // Ack consumed to keep toggle parity aligned, but the line is discarded.
            valid_d = 1'b0;
            ready_d = 1'b1;
            state_d = IDLE;
          end else begin
            line_d  = i_sd_data;
            tag_d   = sd_addr_q;
            valid_d = 1'b1;
            state_d = DONE;
          end
        end
      end

      DONE: begin
        data_d  = sel_byte(line_q, req_off_q);
        ready_d = 1'b1;
        state_d = IDLE;
`ifdef WAV_FETCH_PREFETCH_EN
        if (!i_flush && !nxt_held) begin
          sd_addr_d = tag_q + TAG_ONE;
          sd_req_d  = ~sd_req_q;
          abort_d   = 1'b0;
          state_d   = PREFETCH;
        end
`endif
      end

`ifdef WAV_FETCH_PREFETCH_EN
      PREFETCH: begin
        if (i_flush) abort_d = 1'b1;
        if (ack_now) begin
          if (!(abort_q || i_flush)) begin
            nline_d  = i_sd_data;
            ntag_d   = sd_addr_q;
            nvalid_d = 1'b1;
          end
          abort_d = 1'b0;
          state_d = IDLE;
          if (miss_pend_q) begin
            sd_addr_d   = pend_tag_q;
            sd_req_d    = ~sd_req_q;
            miss_pend_d = 1'b0;
            state_d     = FETCH;
          end
        end
        if (rd_edge && !miss_pend_q) begin
          req_off_d  = i_addr[2:0];
          pend_tag_d = i_tag;
          if (!i_flush && hit_cur) begin
            data_d  = sel_byte(line_q, i_addr[2:0]);
            ready_d = 1'b1;
          end else if (!i_flush && hit_nxt) begin
            line_d   = nline_q;
            tag_d    = ntag_q;
            valid_d  = 1'b1;
            nvalid_d = 1'b0;
            data_d   = sel_byte(nline_q, i_addr[2:0]);
            ready_d  = 1'b1;
          end else if (ack_now) begin
            ready_d   = 1'b0;
            sd_addr_d = i_tag;
            sd_req_d  = ~sd_req_q;
            abort_d   = 1'b0;
            state_d   = FETCH;
          end else if (!i_flush && !abort_q && (i_tag == sd_addr_q)) begin
            // The line is already on its way: wait for that ack as a demand fill.
            ready_d = 1'b0;
            state_d = FETCH;
          end else begin
            ready_d     = 1'b0;
            miss_pend_d = 1'b1;
          end
        end
      end
`endif

      default: state_d = IDLE;
    endcase
  end

  assign o_data    = data_q;
  assign o_ready   = ready_q;
  assign o_sd_addr = sd_addr_q;
  assign o_sd_req  = sd_req_q;

endmodule

// File: tb/tb_wav_byte_fetch.sv
// Testbench for wav_byte_fetch: scoreboard of expected bytes against an SDRAM toggle-handshake model.
module tb_wav_byte_fetch;
  localparam int ADDR_W = 28;

  logic              clk_sys = 1'b0;
  logic              reset_n;
  logic [ADDR_W-1:0] i_addr;
  logic              i_rd;
  logic              i_flush;
  logic [7:0]        o_data;
  logic              o_ready;
  logic [ADDR_W-4:0] o_sd_addr;
  logic              o_sd_req;
  logic              i_sd_ack;
  logic [63:0]       i_sd_data;

  int checks   = 0;
  int failures = 0;
  int toggles  = 0;
  int ack_dly  = 3;
  logic [ADDR_W-4:0] sd_addr_seen = '0;
  logic [7:0]        last_exp = 8'h00;
  logic [7:0]        exp_q[$];

  wav_byte_fetch #(.ADDR_W(ADDR_W), .RESET_READY(1'b1)) dut (
    .clk_sys   (clk_sys),
    .reset_n   (reset_n),
    .i_addr    (i_addr),
    .i_rd      (i_rd),
    .i_flush   (i_flush),
    .o_data    (o_data),
    .o_ready   (o_ready),
    .o_sd_addr (o_sd_addr),
    .o_sd_req  (o_sd_req),
    .i_sd_ack  (i_sd_ack),
    .i_sd_data (i_sd_data)
  );

  always #5 clk_sys = ~clk_sys;

  function automatic logic [63:0] line_for(input logic [ADDR_W-4:0] tag);
    logic [63:0] l;
    l = '0;
    if (tag == 1) l = 64'h8877665544332211;
    else if (tag == 5) l = 64'hF0E0D0C0B0A09080;
    else for (int k = 0; k < 8; k++) l[8*k +: 8] = {tag[4:0], k[2:0]};
    return l;
  endfunction

  function automatic logic [7:0] exp_byte(input logic [ADDR_W-1:0] a);
    logic [63:0] l;
    l = line_for(a[ADDR_W-1:3]);
    return l[8*a[2:0] +: 8];
  endfunction

  // SDRAM side: counts request toggles and answers each with an ack after ack_dly clocks.
  initial begin
    int cnt;
    bit pend;
    logic last_req;
    logic [ADDR_W-4:0] pend_addr;
    i_sd_ack = 1'b0; i_sd_data = '0; pend = 0; cnt = 0; last_req = 1'b0; pend_addr = '0;
    forever begin
      @(negedge clk_sys);
      if (!reset_n) begin
        i_sd_ack = 1'b0; pend = 0; last_req = 1'b0;
      end else begin
        if (o_sd_req != last_req) begin
          toggles++;
          last_req = o_sd_req;
          sd_addr_seen = o_sd_addr;
        end
        if (pend) begin
          cnt--;
          if (cnt <= 0) begin
            i_sd_data = line_for(pend_addr);
            i_sd_ack  = ~i_sd_ack;
            pend      = 0;
          end
        end else if (o_sd_req != i_sd_ack) begin
          pend = 1; cnt = ack_dly; pend_addr = o_sd_addr;
        end
      end
    end
  end

  task automatic do_read(input logic [ADDR_W-1:0] addr, input bit exp_miss,
                         input bit with_flush, input string nm);
    int t0, lat;
    logic [7:0] exp;
    t0 = toggles;
    @(negedge clk_sys);
    i_addr = addr; i_rd = 1'b1; i_flush = with_flush;
    exp_q.push_back(exp_byte(addr));
    @(negedge clk_sys);
    i_rd = 1'b0; i_flush = 1'b0;
    lat = 1;
    while (o_ready !== 1'b1 && lat < 64) begin
      @(negedge clk_sys);
      lat++;
    end
    exp = exp_q.pop_front();
    $display("read %s addr=%h data=%h expect=%h lat=%0d", nm, addr, o_data, exp, lat);
    checks++;
    if (o_ready !== 1'b1) begin
      failures++;
      $display("FAIL %s_ready: o_ready=%b required 1 within %0d clk", nm, o_ready, lat);
    end else if (o_data !== exp) begin
      failures++;
      $display("FAIL %s_data: o_data=%h required %h", nm, o_data, exp);
    end
    checks++;
    if (!exp_miss && lat != 1) begin
      failures++;
      $display("FAIL %s_hit_latency: latency=%0d required 1", nm, lat);
    end else if (exp_miss && lat < 3) begin
      failures++;
      $display("FAIL %s_miss_latency: latency=%0d required >=3", nm, lat);
    end
    @(negedge clk_sys);
    checks++;
    if ((toggles - t0) != (exp_miss ? 1 : 0)) begin
      failures++;
      $display("FAIL %s_toggles: req toggles=%0d required %0d", nm, toggles - t0, exp_miss ? 1 : 0);
    end
    last_exp = exp;
  endtask

  task automatic check_idle_outputs(input string nm);
    checks++;
    if (o_ready !== 1'b1 || o_sd_req !== 1'b0 || o_data !== 8'h00) begin
      failures++;
      $display("FAIL %s: ready=%b req=%b data=%h required ready=1 req=0 data=00", nm, o_ready, o_sd_req, o_data);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; i_rd = 1'b0; i_flush = 1'b0; i_addr = '0;
    repeat (3) @(negedge clk_sys);
    check_idle_outputs("reset_initial");
    #2 reset_n = 1'b1;
    ack_dly = 12;
    @(negedge clk_sys);
    i_addr = 28'h10; i_rd = 1'b1;
    @(negedge clk_sys);
    i_rd = 1'b0;
    repeat (2) @(negedge clk_sys);
    checks++;
    if (o_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_fetch_busy: o_ready=%b required 0", o_ready);
    end
    #2 reset_n = 1'b0;
    #1 check_idle_outputs("reset_async_mid_fetch");
    repeat (2) @(negedge clk_sys);
    #2 reset_n = 1'b1;
    @(negedge clk_sys);
    check_idle_outputs("reset_release");
    ack_dly = 3;
    exp_q.delete();
    do_read(28'h10, 1'b1, 1'b0, "reset_read_miss");
  endtask

  task automatic test_cold_miss_hits();
    do_read(28'h08, 1'b1, 1'b0, "cold_miss");
    checks++;
    if (sd_addr_seen !== 25'd1) begin
      failures++;
      $display("FAIL cold_sd_addr: o_sd_addr=%h required 1", sd_addr_seen);
    end
    for (int a = 9; a <= 15; a++) do_read(ADDR_W'(a), 1'b0, 1'b0, "seq_hit");
  endtask

  task automatic test_line_crossing();
    do_read(28'h0F, 1'b0, 1'b0, "cross_hit");
    do_read(28'h10, 1'b1, 1'b0, "cross_miss");
    checks++;
    if (sd_addr_seen !== 25'd2) begin
      failures++;
      $display("FAIL cross_sd_addr: o_sd_addr=%h required 2", sd_addr_seen);
    end
  endtask

  task automatic test_flush_mid_fetch();
    int t0, lat;
    t0 = toggles;
    @(negedge clk_sys);
    i_addr = 28'h40; i_rd = 1'b1;
    @(negedge clk_sys);
    i_rd = 1'b0; i_flush = 1'b1;
    @(negedge clk_sys);
    i_flush = 1'b0;
    lat = 2;
    while (o_ready !== 1'b1 && lat < 64) begin
      @(negedge clk_sys);
      lat++;
    end
    $display("read flush_abort addr=%h data=%h lat=%0d", 28'h40, o_data, lat);
    checks++;
    if (o_ready !== 1'b1) begin
      failures++;
      $display("FAIL flush_abort_ready: o_ready=%b required 1", o_ready);
    end
    checks++;
    if (o_data !== last_exp) begin
      failures++;
      $display("FAIL flush_abort_data: o_data=%h required unchanged %h", o_data, last_exp);
    end
    @(negedge clk_sys);
    checks++;
    if (toggles - t0 != 1) begin
      failures++;
      $display("FAIL flush_abort_toggles: req toggles=%0d required 1", toggles - t0);
    end
    do_read(28'h40, 1'b1, 1'b0, "flush_refetch");
  endtask

  task automatic test_ignored_request();
    int t0, lat;
    logic [7:0] exp;
    t0 = toggles;
    @(negedge clk_sys);
    i_addr = 28'h30; i_rd = 1'b1;
    exp_q.push_back(exp_byte(28'h30));
    @(negedge clk_sys);
    i_rd = 1'b0;
    @(negedge clk_sys);
    i_addr = 28'h2B; i_rd = 1'b1;
    @(negedge clk_sys);
    i_rd = 1'b0;
    lat = 3;
    while (o_ready !== 1'b1 && lat < 64) begin
      @(negedge clk_sys);
      lat++;
    end
    exp = exp_q.pop_front();
    $display("read ignored_req addr=%h data=%h expect=%h lat=%0d", 28'h30, o_data, exp, lat);
    checks++;
    if (o_ready !== 1'b1 || o_data !== exp) begin
      failures++;
      $display("FAIL ignored_req_data: ready=%b o_data=%h required ready=1 data=%h", o_ready, o_data, exp);
    end
    repeat (3) @(negedge clk_sys);
    checks++;
    if (toggles - t0 != 1) begin
      failures++;
      $display("FAIL ignored_req_toggles: req toggles=%0d required 1", toggles - t0);
    end
    last_exp = exp;
  endtask

  task automatic test_byte_lanes();
    do_read(28'h2F, 1'b1, 1'b0, "lane7");
    do_read(28'h28, 1'b0, 1'b0, "lane0");
    do_read(28'h2B, 1'b0, 1'b0, "lane3");
    checks++;
    if (last_exp !== 8'hB0 || o_data !== 8'hB0) begin
      failures++;
      $display("FAIL lane3_value: o_data=%h required b0", o_data);
    end
  endtask

  task automatic test_flush_idle();
    @(negedge clk_sys);
    i_flush = 1'b1;
    @(negedge clk_sys);
    i_flush = 1'b0;
    checks++;
    if (o_ready !== 1'b1 || o_data !== last_exp) begin
      failures++;
      $display("FAIL flush_idle_outputs: ready=%b data=%h required ready=1 data=%h", o_ready, o_data, last_exp);
    end
    do_read(28'h2B, 1'b1, 1'b0, "flush_idle_refetch");
    do_read(28'h2C, 1'b1, 1'b1, "flush_with_request");
    do_read(28'h2D, 1'b0, 1'b0, "after_flush_hit");
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_cold_miss_hits();
    test_line_crossing();
    test_flush_mid_fetch();
    test_ignored_request();
    test_byte_lanes();
    test_flush_idle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
